// File: rtl/lomo_frame_rx_pkg.sv
// ---------------------------------------------------------------------------
// lomo_frame_rx_pkg : LOMO link widths, header field slices, FSM encodings
// rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package lomo_frame_rx_pkg;

  localparam int LOMO_WORD_W        = 16;
  localparam int LOMO_WORDS_PER_STR = 20;
  localparam int LOMO_FRM_W         = 9;
  localparam int LOMO_STR_W         = 6;
  localparam int LOMO_IDX_W         = 5;

  localparam int LOMO_FRM_HI  = 15;
  localparam int LOMO_FRM_LO  = 7;
  localparam int LOMO_STR_HI  = 6;
  localparam int LOMO_STR_LO  = 1;
  localparam int LOMO_HALF_BIT = 0;

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_RECV = 1'b1;

endpackage

`default_nettype wire

// File: rtl/lomo_frame_rx_if.sv
// ---------------------------------------------------------------------------
// lomo_frame_rx_if : serial link inputs and decoded word/status outputs
// rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

interface lomo_frame_rx_if;
  import lomo_frame_rx_pkg::*;

  logic                     mk;
  logic                     sclk;
  logic                     sdat;
  logic [LOMO_WORD_W-1:0]   word_data;
  logic [LOMO_IDX_W-1:0]    word_idx;
  logic                     word_valid;
  logic [LOMO_FRM_W-1:0]    frm_num;
  logic [LOMO_STR_W-1:0]    str_num;
  logic                     str_done;
  logic                     err_hdr;
  logic                     err_mk;
  logic                     err_tmo;
  logic                     busy;

  modport master (
    input  mk, sclk, sdat,
    output word_data, word_idx, word_valid, frm_num, str_num,
           str_done, err_hdr, err_mk, err_tmo, busy
  );

  modport slave (
    output mk, sclk, sdat,
    input  word_data, word_idx, word_valid, frm_num, str_num,
           str_done, err_hdr, err_mk, err_tmo, busy
  );

endinterface

`default_nettype wire

// File: rtl/lomo_edge_sync.sv
// ---------------------------------------------------------------------------
// lomo_edge_sync : multi-flop synchronizer with optional rising-front output
// rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module lomo_edge_sync #(
  parameter int SYNC_STAGES = 3,
  parameter bit RISE        = 1'b1
) (
  input  wire  clk,
  input  wire  reset,
  input  wire  d,
  output logic q
);

  // Level taps are read at the stage where fronts are detected, so the
  // level chain needs one flop fewer than the front chain.
  localparam int c_DEPTH = RISE ? SYNC_STAGES : SYNC_STAGES - 1;

  logic [c_DEPTH-1:0] r_sync;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_sync <= '0;
    else        r_sync <= c_DEPTH'({r_sync, d});
  end

  generate
    if (RISE) begin : g_rise
      assign q = r_sync[SYNC_STAGES-2] & ~r_sync[SYNC_STAGES-1];
    end else begin : g_level
      assign q = r_sync[c_DEPTH-1];
    end
  endgenerate

endmodule

`default_nettype wire

// File: rtl/lomo_frame_rx.sv
// ---------------------------------------------------------------------------
// lomo_frame_rx : LOMO serial string receiver, word recovery and header checks
// rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module lomo_frame_rx
  import lomo_frame_rx_pkg::*;
#(
  parameter int WORDS_PER_STR = LOMO_WORDS_PER_STR,
  parameter int WORD_W        = LOMO_WORD_W,
  parameter int TIMEOUT       = 4096,
  parameter int SYNC_STAGES   = 3
) (
  input wire              clk,
  input wire              reset,
  lomo_frame_rx_if.master rx
);

  localparam int c_BIT_W = $clog2(WORD_W);
  localparam int c_IDX_W = LOMO_IDX_W;
  localparam int c_TMO_W = $clog2(TIMEOUT);

  localparam logic [c_BIT_W-1:0] c_LAST_BIT  = c_BIT_W'(WORD_W - 1);
  localparam logic [c_IDX_W-1:0] c_LAST_IDX  = c_IDX_W'(WORDS_PER_STR - 1);
  localparam logic [c_IDX_W-1:0] c_HALF_IDX  = c_IDX_W'(WORDS_PER_STR / 2);
  // Abort fires as the idle count steps onto TIMEOUT-1, i.e. TIMEOUT clk after the last front.
  localparam logic [c_TMO_W-1:0] c_TMO_LAST  = c_TMO_W'(TIMEOUT - 2);

  logic               w_mk_rise;
  logic               w_sclk_rise;
  logic               w_sdat;
  logic [WORD_W-1:0]  w_word;
  logic               w_bit_done;
  logic               w_str_end;

  logic [0:0]         r_state;
  logic [WORD_W-1:0]  r_shift;
  logic [c_BIT_W-1:0] r_bit_cnt;
  logic [c_IDX_W-1:0] r_word_cnt;
  logic [c_TMO_W-1:0] r_tmo_cnt;
  logic [WORD_W-2:0]  r_hdr;

  lomo_edge_sync #(.SYNC_STAGES(SYNC_STAGES), .RISE(1'b1)) u_sync_mk (
    .clk(clk), .reset(reset), .d(rx.mk), .q(w_mk_rise)
  );
  lomo_edge_sync #(.SYNC_STAGES(SYNC_STAGES), .RISE(1'b1)) u_sync_sclk (
    .clk(clk), .reset(reset), .d(rx.sclk), .q(w_sclk_rise)
  );
  lomo_edge_sync #(.SYNC_STAGES(SYNC_STAGES), .RISE(1'b0)) u_sync_sdat (
    .clk(clk), .reset(reset), .d(rx.sdat), .q(w_sdat)
  );

  assign w_word     = {r_shift[WORD_W-2:0], w_sdat};
  assign w_bit_done = (r_state == S_RECV) && w_sclk_rise && (r_bit_cnt == c_LAST_BIT);
  assign w_str_end  = w_bit_done && (r_word_cnt == c_LAST_IDX);
  assign rx.busy    = (r_state == S_RECV);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state       <= S_IDLE;
      r_shift       <= '0;
      r_bit_cnt     <= '0;
      r_word_cnt    <= '0;
      r_tmo_cnt     <= '0;
      r_hdr         <= '0;
      rx.word_data  <= '0;
      rx.word_idx   <= '0;
      rx.word_valid <= 1'b0;
      rx.frm_num    <= '0;
      rx.str_num    <= '0;
      rx.str_done   <= 1'b0;
      rx.err_hdr    <= 1'b0;
      rx.err_mk     <= 1'b0;
      rx.err_tmo    <= 1'b0;
    end else begin
      rx.word_valid <= 1'b0;
      rx.str_done   <= 1'b0;
      rx.err_hdr    <= 1'b0;
      rx.err_mk     <= 1'b0;
      rx.err_tmo    <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_mk_rise) begin
            r_state    <= S_RECV;
            r_word_cnt <= '0;
            r_tmo_cnt  <= '0;
            // A coincident sclk front is the first (MSB) bit of the new string.
            if (w_sclk_rise) begin
              r_shift   <= w_word;
              r_bit_cnt <= c_BIT_W'(1);
            end else begin
              r_bit_cnt <= '0;
            end
          end
        end
        default: begin
          if (w_mk_rise && !w_str_end) begin
            rx.err_mk  <= 1'b1;
            r_bit_cnt  <= '0;
            r_word_cnt <= '0;
            r_tmo_cnt  <= '0;
          end else if (w_sclk_rise) begin
            r_shift   <= w_word;
            r_tmo_cnt <= '0;
            r_bit_cnt <= w_bit_done ? '0 : r_bit_cnt + 1'b1;
            if (w_bit_done) begin
              rx.word_data  <= w_word;
              rx.word_idx   <= r_word_cnt;
              rx.word_valid <= 1'b1;
              r_word_cnt    <= r_word_cnt + 1'b1;
              if (r_word_cnt == '0) begin
                rx.err_hdr <= ~w_word[LOMO_HALF_BIT];
                r_hdr      <= w_word[WORD_W-1:1];
                rx.frm_num <= w_word[LOMO_FRM_HI:LOMO_FRM_LO];
                rx.str_num <= w_word[LOMO_STR_HI:LOMO_STR_LO];
              end
              if (r_word_cnt == c_HALF_IDX) begin
                rx.err_hdr <= w_word[LOMO_HALF_BIT] | (w_word[WORD_W-1:1] != r_hdr);
              end
              if (w_str_end) begin
                rx.str_done <= 1'b1;
                r_word_cnt  <= '0;
                // A marker on the final bit opens the next string cleanly.
                if (!w_mk_rise) r_state <= S_IDLE;
              end
            end
          end else if (r_tmo_cnt == c_TMO_LAST) begin
            rx.err_tmo <= 1'b1;
            r_state    <= S_IDLE;
          end else begin
            r_tmo_cnt <= r_tmo_cnt + 1'b1;
          end
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_lomo_frame_rx.sv
// ---------------------------------------------------------------------------
// tb_lomo_frame_rx : randomized scoreboard bench for lomo_frame_rx
// rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_lomo_frame_rx;
  import lomo_frame_rx_pkg::*;

  localparam int TIMEOUT = 64;
  localparam int SYNC    = 3;
  localparam int NW      = 20;

  typedef enum int {EV_WORD, EV_MK, EV_TMO} ev_kind_e;
  typedef struct {
    ev_kind_e    kind;
    logic [15:0] data;
    logic [4:0]  idx;
    logic        hdr;
    logic        done;
    logic [8:0]  frm;
    logic [5:0]  str;
  } ev_t;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  lomo_frame_rx_if bus();

  lomo_frame_rx #(
    .WORDS_PER_STR(NW), .WORD_W(16), .TIMEOUT(TIMEOUT), .SYNC_STAGES(SYNC)
  ) dut (
    .clk(clk), .reset(reset), .rx(bus.master)
  );

  ev_t         exp_q[$];
  ev_t         m_e;
  int          checks = 0;
  int          failures = 0;
  logic [8:0]  m_frm = '0;
  logic [5:0]  m_str = '0;
  logic [15:0] cur_w [NW];
  longint      t_rise = 0;
  logic [63:0] m_got, m_exp;
  int          tmo_n;
  bit          tmo_seen;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  function automatic logic [63:0] outs();
    return {22'b0, bus.word_data, bus.word_idx, bus.word_valid, bus.frm_num, bus.str_num,
            bus.str_done, bus.err_hdr, bus.err_mk, bus.err_tmo, bus.busy};
  endfunction

  // Scoreboard monitor: every output event consumes one expected event.
  initial forever begin
    @(negedge clk);
    if (reset && (bus.word_valid | bus.err_mk | bus.err_tmo | bus.err_hdr | bus.str_done)) begin
      m_got = {23'b0, bus.word_valid, bus.err_mk, bus.err_tmo, bus.err_hdr, bus.str_done,
               bus.word_valid ? {bus.word_data, bus.word_idx, bus.frm_num, bus.str_num} : 36'b0};
      if (exp_q.size() == 0) begin
        check("unexpected_event", m_got, 64'b0);
      end else begin
        m_e = exp_q.pop_front();
        m_exp = {23'b0, m_e.kind == EV_WORD, m_e.kind == EV_MK, m_e.kind == EV_TMO, m_e.hdr, m_e.done,
                 (m_e.kind == EV_WORD) ? {m_e.data, m_e.idx, m_e.frm, m_e.str} : 36'b0};
        check($sformatf("event_idx%0d", m_e.idx), m_got, m_exp);
      end
    end
  end

  initial begin
    #900000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_bit(input logic b, input logic with_mk);
    bus.sdat = b;
    tick($urandom_range(2, 4));
    bus.sclk = 1'b1;
    if (with_mk) bus.mk = 1'b1;
    t_rise = $time;
    tick($urandom_range(2, 4));
    bus.sclk = 1'b0;
    bus.mk   = 1'b0;
  endtask

  task automatic mk_pulse();
    bus.mk = 1'b1;
    tick(3);
    bus.mk = 1'b0;
    tick(2);
  endtask

  task automatic gen_string(input logic [8:0] frm, input logic [5:0] str);
    for (int k = 0; k < NW; k++) cur_w[k] = 16'($urandom);
    cur_w[0]    = {frm, str, 1'b1};
    cur_w[NW/2] = {frm, str, 1'b0};
  endtask

  // Reference: a word is flagged if its header rule (w00 odd; w10 even and equal to w00 above bit 0) fails.
  task automatic expect_word(input int k);
    ev_t e;
    if (k == 0) begin
      m_frm = cur_w[0][15:7];
      m_str = cur_w[0][6:1];
    end
    e.kind = EV_WORD;
    e.data = cur_w[k];
    e.idx  = 5'(k);
    e.done = (k == NW - 1);
    e.frm  = m_frm;
    e.str  = m_str;
    if (k == 0)           e.hdr = (cur_w[0] % 2) == 0;
    else if (k == NW / 2) e.hdr = ((cur_w[k] % 2) != 0) || ((cur_w[k] / 2) != (cur_w[0] / 2));
    else                  e.hdr = 1'b0;
    exp_q.push_back(e);
  endtask

  task automatic expect_err(input ev_kind_e kind);
    ev_t e;
    e.kind = kind; e.data = '0; e.idx = '0; e.hdr = 1'b0; e.done = 1'b0; e.frm = '0; e.str = '0;
    exp_q.push_back(e);
  endtask

  // start: 0 = separate marker pulse, 1 = marker with first bit, 2 = string already open
  task automatic send_string(input int nbits, input int start, input bit end_mk);
    if (start == 0) mk_pulse();
    for (int i = 0; i < nbits; i++) begin
      int k;
      k = i / 16;
      if (i % 16 == 15) expect_word(k);
      send_bit(cur_w[k][15 - (i % 16)], (start == 1 && i == 0) || (end_mk && i == nbits - 1));
    end
  endtask

  initial begin
    bus.mk = 1'b0; bus.sclk = 1'b0; bus.sdat = 1'b0;
    tick(5);
    check("reset_state", outs(), 64'b0);
    reset = 1'b1;
    tick(5);

    // Nominal string frm=5 str=3
    gen_string(9'd5, 6'd3);
    check("t1_w00_w10", {32'b0, cur_w[0], cur_w[10]}, {32'b0, 16'h0287, 16'h0286});
    send_string(320, 0, 1'b0);
    tick(8);
    check("t1_frm_str_busy", {48'b0, bus.frm_num, bus.str_num, bus.busy}, {48'b0, 9'd5, 6'd3, 1'b0});

    // Header mismatch in w10, marker coincident with first bit
    gen_string(9'd5, 6'd3);
    cur_w[10] = 16'h0288;
    send_string(320, 1, 1'b0);
    tick(8);

    // Short string aborted by marker, then a full string
    gen_string(9'($urandom), 6'($urandom));
    send_string(8 * 16 + 5, 0, 1'b0);
    expect_err(EV_MK);
    mk_pulse();
    gen_string(9'($urandom), 6'($urandom));
    send_string(320, 2, 1'b0);
    tick(8);

    // Stall after word 2 bit 9
    gen_string(9'($urandom), 6'($urandom));
    send_string(2 * 16 + 10, 0, 1'b0);
    expect_err(EV_TMO);
    tmo_seen = 1'b0;
    tmo_n = 0;
    while (!tmo_seen && tmo_n < TIMEOUT + 50) begin
      @(negedge clk);
      tmo_n++;
      if (bus.err_tmo) tmo_seen = 1'b1;
    end
    check("t4_tmo_latency", 64'(($time - t_rise) / 10), 64'(TIMEOUT + SYNC - 1));
    check("t4_busy", {63'b0, bus.busy}, 64'b0);
    tick(100);

    // Back-to-back: next marker on the final bit of word 19
    gen_string(9'($urandom), 6'($urandom));
    send_string(320, 0, 1'b1);
    gen_string(9'($urandom), 6'($urandom));
    send_string(320, 2, 1'b0);
    tick(8);

    // Reset mid-word 12
    gen_string(9'($urandom), 6'($urandom));
    send_string(12 * 16 + 7, 0, 1'b0);
    #2 reset = 1'b0;
    #1 check("t6_reset_outputs", outs(), 64'b0);
    exp_q.delete();
    m_frm = '0;
    m_str = '0;
    tick(3);
    reset = 1'b1;
    tick(3);
    gen_string(9'($urandom), 6'($urandom));
    send_string(320, 0, 1'b0);
    tick(8);

    // Random strings with occasional header corruption
    for (int r = 0; r < 4; r++) begin
      gen_string(9'($urandom), 6'($urandom));
      if ($urandom_range(0, 3) == 0) cur_w[0][0] = 1'b0;
      if ($urandom_range(0, 2) == 0) cur_w[10][$urandom_range(0, 15)] ^= 1'b1;
      send_string(320, int'($urandom_range(0, 1)), 1'b0);
      tick(8);
    end

    tick(20);
    check("queue_drained", 64'(exp_q.size()), 64'b0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
